// File: rtl/acq_pkg.sv
// Shared state encoding and constants for the acquisition trigger sequencer.
package acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_COMP_RST = 3'd3,
        ST_HOLDOFF  = 3'd4,
        ST_DONE     = 3'd5
    } acq_state_e;

    localparam logic [7:0] MISSED_MAX = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == MISSED_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/acq_trig_qualifier.sv
// Masked rising-edge trigger detect plus software trigger; combinational outputs
// from one registered history bit per source.
module acq_trig_qualifier
    import acq_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] trig_in,
    input  logic [NUM_SRC-1:0] mask,
    input  logic               manual,
    output logic               trig_pulse,
    output logic [NUM_SRC-1:0] src_vec
);

    logic [NUM_SRC-1:0] masked;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] edge_vec;

    assign masked = trig_in & mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_q <= '0;
        else       prev_q <= masked;
    end

    assign edge_vec   = masked & ~prev_q;
    assign trig_pulse = manual | (|edge_vec);
    assign src_vec    = manual ? '1 : edge_vec;

endmodule

// File: rtl/acq_trigger_sequencer.sv
// Arms, qualifies triggers and gates fixed-length record writes (wr_en 1 cycle after trigger);
// store_full rejects triggers. Optional TRIG_TIMESTAMP_EN adds trig_ts/ts_valid.
module acq_trigger_sequencer
    import acq_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int LEN_W   = 12,
    parameter int EVT_W   = 8,
    parameter int HOLD_W  = 16,
    parameter int RST_CYC = 4
`ifdef TRIG_TIMESTAMP_EN
    , parameter int TS_W  = 32
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_arm,
    input  logic               cfg_disarm,
    input  logic               cfg_auto_rearm,
    input  logic               cfg_manual_trig,
    input  logic [NUM_SRC-1:0] cfg_src_mask,
    input  logic [EVT_W-1:0]   cfg_num_events,
    input  logic [LEN_W-1:0]   cfg_post_len,
    input  logic [HOLD_W-1:0]  cfg_holdoff,
    input  logic [NUM_SRC-1:0] trig_in,
    input  logic               store_full,
    input  logic               readout_done,
    output logic               wr_en,
    output logic               wr_last,
    output logic               comp_reset,
    output logic               armed,
    output logic               acq_done,
    output logic [NUM_SRC-1:0] src_latched,
    output logic [7:0]         missed_trig,
`ifdef TRIG_TIMESTAMP_EN
    output logic [TS_W-1:0]    trig_ts,
    output logic               ts_valid,
`endif
    output logic [2:0]         state
);

    localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    acq_state_e         state_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [LEN_W-1:0]   len_q, len_cnt_q;
    logic [EVT_W-1:0]   evt_num_q, evt_q;
    logic [HOLD_W-1:0]  hold_q, hold_cnt_q;
    logic [RC_W-1:0]    rst_cnt_q;
    logic               dis_pend_q;
    logic               wr_en_q, wr_last_q, comp_reset_q, armed_q, done_q;
    logic [NUM_SRC-1:0] src_q;
    logic [7:0]         missed_q;

    logic               trig_pulse;
    logic [NUM_SRC-1:0] src_vec;
    logic [EVT_W-1:0]   evt_d, evt_goal;
    logic               finish, accept, miss_ev, busy;

    acq_trig_qualifier #(.NUM_SRC(NUM_SRC)) u_qual (
        .clk        (clk),
        .reset      (reset),
        .trig_in    (trig_in),
        .mask       (mask_q),
        .manual     (cfg_manual_trig),
        .trig_pulse (trig_pulse),
        .src_vec    (src_vec)
    );

    // Programming zero events still yields one record per acquisition.
    assign evt_d    = evt_q + EVT_W'(1);
    assign evt_goal = (evt_num_q == '0) ? EVT_W'(1) : evt_num_q;
    assign finish   = (evt_d == evt_goal) || dis_pend_q || cfg_disarm;
    assign busy     = (state_q == ST_CAPTURE) || (state_q == ST_COMP_RST) || (state_q == ST_HOLDOFF);
    assign accept   = (state_q == ST_ARMED) && !cfg_disarm && trig_pulse && !store_full;
    assign miss_ev  = trig_pulse && (busy || ((state_q == ST_ARMED) && !cfg_disarm && store_full));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            len_q        <= '0;
            evt_num_q    <= '0;
            hold_q       <= '0;
            evt_q        <= '0;
            len_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            rst_cnt_q    <= '0;
            dis_pend_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_last_q    <= 1'b0;
            comp_reset_q <= 1'b0;
            armed_q      <= 1'b0;
            done_q       <= 1'b0;
            src_q        <= '0;
        end else begin
            if (cfg_disarm && (busy || state_q == ST_DONE)) dis_pend_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_arm && !cfg_disarm) begin
                        mask_q     <= cfg_src_mask;
                        len_q      <= cfg_post_len;
                        evt_num_q  <= cfg_num_events;
                        hold_q     <= cfg_holdoff;
                        evt_q      <= '0;
                        dis_pend_q <= 1'b0;
                        armed_q    <= 1'b1;
                        state_q    <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (cfg_disarm) begin
                        armed_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (accept) begin
                        armed_q   <= 1'b0;
                        wr_en_q   <= 1'b1;
                        wr_last_q <= (len_q == '0);
                        len_cnt_q <= '0;
                        src_q     <= src_vec;
                        state_q   <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (len_cnt_q == len_q) begin
                        wr_en_q      <= 1'b0;
                        wr_last_q    <= 1'b0;
                        comp_reset_q <= 1'b1;
                        rst_cnt_q    <= '0;
                        state_q      <= ST_COMP_RST;
                    end else begin
                        len_cnt_q <= len_cnt_q + LEN_W'(1);
                        wr_last_q <= ((len_cnt_q + LEN_W'(1)) == len_q);
                    end
                end
                ST_COMP_RST: begin
                    if (rst_cnt_q == RC_W'(RST_CYC - 1)) begin
                        comp_reset_q <= 1'b0;
                        if (hold_q == '0) begin
                            evt_q   <= evt_d;
                            done_q  <= finish;
                            armed_q <= !finish;
                            state_q <= finish ? ST_DONE : ST_ARMED;
                        end else begin
                            hold_cnt_q <= '0;
                            state_q    <= ST_HOLDOFF;
                        end
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RC_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt_q == hold_q - HOLD_W'(1)) begin
                        evt_q   <= evt_d;
                        done_q  <= finish;
                        armed_q <= !finish;
                        state_q <= finish ? ST_DONE : ST_ARMED;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                ST_DONE: begin
                    if (readout_done) begin
                        done_q     <= 1'b0;
                        dis_pend_q <= 1'b0;
                        evt_q      <= '0;
                        if (cfg_auto_rearm && !dis_pend_q && !cfg_disarm) begin
                            armed_q <= 1'b1;
                            state_q <= ST_ARMED;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Only an accepted arm clears the rejected-trigger count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                              missed_q <= '0;
        else if (state_q == ST_IDLE && cfg_arm && !cfg_disarm) missed_q <= '0;
        else if (miss_ev)                                       missed_q <= sat_inc(missed_q);
    end

`ifdef TRIG_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q, trig_ts_q;
    logic            ts_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt_q   <= '0;
            trig_ts_q  <= '0;
            ts_valid_q <= 1'b0;
        end else begin
            ts_cnt_q   <= ts_cnt_q + TS_W'(1);
            ts_valid_q <= accept;
            if (accept) trig_ts_q <= ts_cnt_q;
        end
    end

    assign trig_ts  = trig_ts_q;
    assign ts_valid = ts_valid_q;
`endif

    assign wr_en       = wr_en_q;
    assign wr_last     = wr_last_q;
    assign comp_reset  = comp_reset_q;
    assign armed       = armed_q;
    assign acq_done    = done_q;
    assign src_latched = src_q;
    assign missed_trig = missed_q;
    assign state       = state_q;

endmodule

// File: tb/tb_acq_trigger_sequencer.sv
// Directed and randomized bench; expectations come from a per-record timeline model.
module tb_acq_trigger_sequencer;

    localparam int RST = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_arm, cfg_disarm, cfg_auto_rearm, cfg_manual_trig;
    logic [1:0]  cfg_src_mask;
    logic [7:0]  cfg_num_events;
    logic [11:0] cfg_post_len;
    logic [15:0] cfg_holdoff;
    logic [1:0]  trig_in;
    logic        store_full, readout_done;
    logic        wr_en, wr_last, comp_reset, armed, acq_done;
    logic [1:0]  src_latched;
    logic [7:0]  missed_trig;
    logic [2:0]  state;

    int          checks = 0;
    int          errors = 0;
    int          exp_missed;
    logic [1:0]  exp_src;

    acq_trigger_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_arm         (cfg_arm),
        .cfg_disarm      (cfg_disarm),
        .cfg_auto_rearm  (cfg_auto_rearm),
        .cfg_manual_trig (cfg_manual_trig),
        .cfg_src_mask    (cfg_src_mask),
        .cfg_num_events  (cfg_num_events),
        .cfg_post_len    (cfg_post_len),
        .cfg_holdoff     (cfg_holdoff),
        .trig_in         (trig_in),
        .store_full      (store_full),
        .readout_done    (readout_done),
        .wr_en           (wr_en),
        .wr_last         (wr_last),
        .comp_reset      (comp_reset),
        .armed           (armed),
        .acq_done        (acq_done),
        .src_latched     (src_latched),
        .missed_trig     (missed_trig),
        .state           (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; pulse inputs set since the previous tick are seen at exactly one edge.
    task automatic tick();
        @(posedge clk);
        #2;
        cfg_arm         = 1'b0;
        cfg_disarm      = 1'b0;
        cfg_manual_trig = 1'b0;
        trig_in         = 2'b00;
        readout_done    = 1'b0;
    endtask

    task automatic arm(input logic [1:0] m, input int len, input int ev, input int hold);
        cfg_src_mask   = m;
        cfg_post_len   = 12'(len);
        cfg_num_events = 8'(ev);
        cfg_holdoff    = 16'(hold);
        cfg_arm        = 1'b1;
        tick();
        exp_missed = 0;
        chk("arm_state", state, 1);
        chk("arm_armed", armed, 1);
        chk("arm_missed_clr", missed_trig, 0);
    endtask

    // src < 0 selects the software trigger.
    task automatic fire(input int src);
        if (src < 0) begin
            cfg_manual_trig = 1'b1;
            exp_src = 2'b11;
        end else begin
            trig_in[src] = 1'b1;
            exp_src = 2'b00;
            exp_src[src] = 1'b1;
        end
    endtask

    // Record timeline after an accepted trigger: L+1 writes, RST reset cycles, H holdoff
    // cycles, then ARMED or DONE. inj_k/dis_k inject a trigger or disarm at that offset.
    task automatic run_record(input int L, input int H, input bit last,
                              input int inj_k, input int dis_k);
        int total;
        int exp_st;
        total = L + 2 + RST + H;
        for (int k = 1; k <= total; k++) begin
            tick();
            if (k <= L + 1)                exp_st = 2;
            else if (k <= L + 1 + RST)     exp_st = 3;
            else if (k <= L + 1 + RST + H) exp_st = 4;
            else                           exp_st = last ? 5 : 1;
            chk("wr_en", wr_en, (k <= L + 1) ? 1 : 0);
            chk("wr_last", wr_last, (k == L + 1) ? 1 : 0);
            chk("comp_reset", comp_reset, (k >= L + 2 && k <= L + 1 + RST) ? 1 : 0);
            chk("rec_state", state, exp_st);
            if (k == inj_k) begin
                cfg_manual_trig = 1'b1;
                if (exp_missed < 255) exp_missed++;
            end
            if (k == dis_k) cfg_disarm = 1'b1;
        end
        chk("src_latched", src_latched, exp_src);
        chk("missed", missed_trig, exp_missed);
        chk("acq_done", acq_done, last ? 1 : 0);
        chk("armed_after", armed, last ? 0 : 1);
    endtask

    initial begin
        int   L, H, ev, ne, wait_n, inj, src;
        logic [1:0] m;
        bit   saw_wr;

        reset = 1'b1;
        cfg_arm = 0; cfg_disarm = 0; cfg_auto_rearm = 0; cfg_manual_trig = 0;
        cfg_src_mask = 0; cfg_num_events = 0; cfg_post_len = 0; cfg_holdoff = 0;
        trig_in = 0; store_full = 0; readout_done = 0;
        tick();
        tick();
        chk("rst_state", state, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_last", wr_last, 0);
        chk("rst_comp_reset", comp_reset, 0);
        chk("rst_armed", armed, 0);
        chk("rst_done", acq_done, 0);
        chk("rst_missed", missed_trig, 0);
        chk("rst_src", src_latched, 0);
        reset = 1'b0;
        tick();

        // Single 8-sample record, immediate DONE, manual readout back to IDLE.
        arm(2'b01, 7, 1, 0);
        fire(0);
        run_record(7, 0, 1, 0, 0);
        readout_done = 1'b1;
        tick();
        chk("t1_idle", state, 0);
        chk("t1_done_clr", acq_done, 0);

        // Three events with holdoff, triggers 40 cycles apart.
        arm(2'b01, 7, 3, 10);
        for (int i = 0; i < 3; i++) begin
            fire(0);
            run_record(7, 10, i == 2, 0, 0);
            if (i < 2) begin
                for (int w = 0; w < 17; w++) tick();
                chk("t2_wait_armed", state, 1);
            end
        end
        readout_done = 1'b1;
        tick();
        chk("t2_idle", state, 0);

        // Masked-off source ignored; a trigger mid-capture is counted as missed.
        arm(2'b01, 20, 1, 0);
        for (int i = 0; i < 3; i++) begin
            trig_in[1] = 1'b1;
            tick();
            tick();
        end
        chk("t3_masked_state", state, 1);
        chk("t3_masked_missed", missed_trig, 0);
        chk("t3_masked_wr", wr_en, 0);
        fire(0);
        run_record(20, 0, 1, 5, 0);
        chk("t3_missed_one", missed_trig, 1);
        readout_done = 1'b1;
        tick();

        // Storage full: every trigger rejected, counter saturates.
        arm(2'b01, 3, 1, 0);
        store_full = 1'b1;
        saw_wr = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cfg_manual_trig = 1'b1;
            tick();
            if (wr_en !== 1'b0) saw_wr = 1'b1;
        end
        chk("t4_no_wr", saw_wr, 0);
        chk("t4_missed_sat", missed_trig, 255);
        chk("t4_still_armed", state, 1);
        cfg_post_len = 12'd9;
        cfg_arm = 1'b1;
        tick();
        chk("t4_arm_ignored_missed", missed_trig, 255);
        chk("t4_arm_ignored_state", state, 1);
        store_full = 1'b0;
        cfg_disarm = 1'b1;
        tick();
        chk("t4_disarm_idle", state, 0);
        chk("t4_disarm_armed", armed, 0);
        cfg_arm = 1'b1;
        cfg_disarm = 1'b1;
        tick();
        chk("arm_disarm_together", state, 0);

        // Disarm on the 3rd sample: record completes, DONE, then IDLE despite auto re-arm.
        cfg_auto_rearm = 1'b1;
        arm(2'b01, 15, 3, 5);
        fire(0);
        run_record(15, 5, 1, 0, 3);
        readout_done = 1'b1;
        tick();
        chk("t5_idle_after_disarm", state, 0);

        // Randomized configurations with auto re-arm across two acquisitions each.
        for (int cfg = 0; cfg < 5; cfg++) begin
            m  = 2'($urandom_range(1, 3));
            L  = $urandom_range(0, 12);
            H  = $urandom_range(0, 8);
            ev = (cfg == 0) ? 0 : $urandom_range(1, 3);
            ne = (ev == 0) ? 1 : ev;
            cfg_auto_rearm = 1'b1;
            arm(m, L, ev, H);
            for (int acq = 0; acq < 2; acq++) begin
                for (int e = 0; e < ne; e++) begin
                    wait_n = $urandom_range(0, 3);
                    for (int w = 0; w < wait_n; w++) tick();
                    chk("rnd_armed", state, 1);
                    if ($urandom_range(0, 2) == 0) src = -1;
                    else if (m == 2'b11) src = $urandom_range(0, 1);
                    else src = (m == 2'b01) ? 0 : 1;
                    inj = ($urandom_range(0, 1) == 1) ? $urandom_range(2, L + 5 + H) : 0;
                    fire(src);
                    run_record(L, H, e == ne - 1, inj, 0);
                end
                readout_done = 1'b1;
                tick();
                chk("rnd_auto_rearm", state, 1);
                chk("rnd_rearm_armed", armed, 1);
            end
            cfg_auto_rearm = 1'b0;
            cfg_disarm = 1'b1;
            tick();
            chk("rnd_disarm_idle", state, 0);
        end

        // Asynchronous reset in the middle of a record.
        arm(2'b01, 15, 1, 0);
        fire(0);
        tick();
        tick();
        tick();
        chk("t6_mid_wr", wr_en, 1);
        reset = 1'b1;
        #1;
        chk("t6_async_wr", wr_en, 0);
        chk("t6_async_state", state, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_post_state", state, 0);
        chk("t6_post_missed", missed_trig, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
